pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Executes the PC function codes (PC_FS) and the k_mux-selected branch offset produced by the branch control unit.
- Owns the 64-bit program counter and the link value (PC+4) used for BL.
- Runs the instruction-fetch handshake with instruction memory and delivers fetched words to the IR with a one-cycle valid strobe.
- Sits between the control units, the register-file bus (BR target) and instruction memory.

Parameters:
- WIDTH, 64, PC/address width in bits.
- RESET_PC, 64'h0, PC value loaded on reset.
- FETCH_TIMEOUT, 15, maximum cycles spent in REQ waiting for mem_ack before faulting; 4-bit counter range, legal values 1..15.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- pc_update  input  1  strobe from the CU: apply PC_FS this cycle.
- PC_FS  input  2  PC function: 00 hold, 01 PC+4, 10 load pc_in, 11 PC+(k<<2).
- k  input  WIDTH  sign-extended word offset selected by k_mux.
- pc_in  input  WIDTH  register value used for BR (PC_FS=10).
- fetch_start  input  1  request a fetch at the current PC.
- mem_ack  input  1  instruction memory data valid.
- mem_rdata  input  32  instruction word from memory.
- PC  output  WIDTH  current program counter.
- PC4  output  WIDTH  PC+4, combinational; link value for BL.
- mem_req  output  1  fetch request, held high until mem_ack.
- mem_addr  output  WIDTH  fetch address, equal to PC while mem_req is high.
- IR  output  32  last fetched instruction.
- IR_valid  output  1  one-cycle pulse when IR is loaded.
- fetch_busy  output  1  high in REQ.
- fault  output  1  sticky: misaligned fetch or timeout.

Behaviour:
- Reset (async):
  - PC=RESET_PC, IR=0, IR_valid=0, mem_req=0, fault=0, timeout counter=0, state=IDLE.
  - Reset asserted mid-REQ drops mem_req immediately (asynchronously); any late mem_ack is ignored.
- PC update (in IDLE only): on a clock edge with pc_update=1, the new PC depends on PC_FS:
  - 00: PC unchanged.
  - 01: PC+4.
  - 10: pc_in.
  - 11: PC+(k<<2).
  - All arithmetic is modulo 2^WIDTH; wrap-around is silent and is not a fault.
  - k is two's complement, so negative offsets branch backward.
- pc_update in REQ or FAULT is ignored; PC stays frozen.
- PC4 is always PC+4, mod 2^WIDTH.
- Misaligned PC values are loaded without check; alignment is checked only at fetch.
- FSM states and transitions:
  - IDLE: mem_req=0. On fetch_start:
    - PC[1:0]!=0 -> FAULT.
    - Otherwise -> REQ and clear the counter.
  - fetch_start and pc_update in the same IDLE cycle: the PC update wins, and the fetch uses the new PC (the alignment check applies to the new PC). Concretely, the state moves to REQ with mem_addr equal to the updated PC.
  - REQ: mem_req=1, mem_addr=PC, fetch_busy=1.
    - On mem_ack: IR<=mem_rdata, IR_valid=1 for the next cycle only, go to IDLE.
    - Else the counter increments; when it reaches FETCH_TIMEOUT without an ack, go to FAULT.
    - A mem_ack on the same cycle the counter hits the limit counts as success.
  - FAULT: fault=1, mem_req=0. Sticky until reset; fetch_start and pc_update are ignored.
- Latency: minimum fetch is fetch_start at edge N, mem_req high in cycle N+1, ack in the same cycle, IR_valid in cycle N+2.
- IR holds its value between fetches. mem_rdata is sampled only on an acked REQ cycle.
- fetch_start while in REQ is ignored; there is no queueing.

Test Plan:
- Reset: after reset, PC=0 and PC4=4. Apply pc_update with PC_FS=01 three times -> PC=12. PC_FS=00 -> PC stays 12.
- Branch: PC=0x100, k=-2 (all ones ...FE), PC_FS=11 -> PC=0xF8. Then pc_in=0x4000, PC_FS=10 -> PC=0x4000.
- Wrap-around: PC=0xFFFF_FFFF_FFFF_FFFC, PC_FS=01 -> PC=0, fault=0.
- Fetch: at PC=0x40, fetch_start, with mem_ack after 3 cycles and mem_rdata=0x9100_0421 -> mem_req high exactly 3 cycles, mem_addr=0x40, IR=0x91000421, IR_valid high for exactly 1 cycle. A pc_update during REQ leaves PC=0x40.
- Faults and reset mid-fetch:
  - pc_in=0x102, PC_FS=10, then fetch_start -> fault=1, mem_req never asserts.
  - Separately, with ack withheld, fault rises after 15 REQ cycles.
  - Reset mid-REQ -> mem_req=0 immediately.
- Simultaneous update and fetch: fetch_start together with pc_update (PC_FS=01) at PC=0x20 -> mem_addr=0x24. An ack on the 15th REQ cycle -> IR loaded, fault=0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter owner and instruction-fetch sequencer.
// Applies PC function codes while idle, runs a request/ack handshake with
// instruction memory, and latches fetched words into IR with a one-cycle
// valid strobe. Misaligned fetches and unanswered requests park the unit in
// a sticky FAULT state that only reset clears.
module pc_fetch_unit #(
  parameter int                 WIDTH         = 64,
  parameter logic [WIDTH-1:0]   RESET_PC      = {WIDTH{1'b0}},
  parameter int                 FETCH_TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pc_update,
  input  logic [1:0]       PC_FS,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             fetch_start,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC4,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  output logic [31:0]      IR,
  output logic             IR_valid,
  output logic             fetch_busy,
  output logic             fault
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_FAULT = 2'b10
  } state_t;

  // Constant +4 step at full PC width; arithmetic wraps modulo 2^WIDTH.
  localparam logic [WIDTH-1:0] PC_STEP_C  = {{(WIDTH-3){1'b0}}, 3'b100};
  localparam logic [3:0]       TIMEOUT_C  = 4'(FETCH_TIMEOUT);

  state_t           state_r;
  logic [WIDTH-1:0] pc_r;
  logic [31:0]      ir_r;
  logic             ir_valid_r;
  logic             mem_req_r;
  logic             busy_r;
  logic             fault_r;
  logic [3:0]       cnt_r;

  logic [WIDTH-1:0] pc_next_s;
  logic [3:0]       cnt_inc_s;

  // Next PC for a given function code; k is a signed word offset.
  function automatic logic [WIDTH-1:0] pc_function(
    input logic [WIDTH-1:0] pc,
    input logic [1:0]       fs,
    input logic [WIDTH-1:0] offset,
    input logic [WIDTH-1:0] target
  );
    logic [WIDTH-1:0] res;
    case (fs)
      2'b00:   res = pc;
      2'b01:   res = pc + PC_STEP_C;
      2'b10:   res = target;
      2'b11:   res = pc + (offset << 2);
      default: res = pc;
    endcase
    return res;
  endfunction

  // Candidate PC for this cycle; only committed while idle.
  always_comb begin
    pc_next_s = pc_r;
    if (pc_update) begin
      pc_next_s = pc_function(pc_r, PC_FS, k, pc_in);
    end else begin
      pc_next_s = pc_r;
    end
  end

  // Timeout counter increment; counter never exceeds the 4-bit limit.
  always_comb begin
    cnt_inc_s = cnt_r + 4'd1;
  end

  // Fetch FSM with registered PC, IR, handshake and status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      pc_r       <= RESET_PC;
      ir_r       <= 32'h0000_0000;
      ir_valid_r <= 1'b0;
      mem_req_r  <= 1'b0;
      busy_r     <= 1'b0;
      fault_r    <= 1'b0;
      cnt_r      <= 4'd0;
    end else begin
      ir_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // Update wins over a simultaneous fetch; the fetch uses the new PC.
          pc_r <= pc_next_s;
          if (fetch_start) begin
            if (pc_next_s[1:0] != 2'b00) begin
              state_r <= ST_FAULT;
              fault_r <= 1'b1;
            end else begin
              state_r   <= ST_REQ;
              mem_req_r <= 1'b1;
              busy_r    <= 1'b1;
              cnt_r     <= 4'd0;
            end
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            // An ack on the limit cycle still counts as success.
            ir_r       <= mem_rdata;
            ir_valid_r <= 1'b1;
            state_r    <= ST_IDLE;
            mem_req_r  <= 1'b0;
            busy_r     <= 1'b0;
          end else if (cnt_inc_s == TIMEOUT_C) begin
            cnt_r     <= cnt_inc_s;
            state_r   <= ST_FAULT;
            fault_r   <= 1'b1;
            mem_req_r <= 1'b0;
            busy_r    <= 1'b0;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        ST_FAULT: begin
          // Sticky until reset; all requests ignored.
          mem_req_r <= 1'b0;
          busy_r    <= 1'b0;
          fault_r   <= 1'b1;
        end
        default: begin
          // Unreachable encoding: fail safe into FAULT.
          state_r   <= ST_FAULT;
          mem_req_r <= 1'b0;
          busy_r    <= 1'b0;
          fault_r   <= 1'b1;
        end
      endcase
    end
  end

  assign PC         = pc_r;
  assign PC4        = pc_r + PC_STEP_C;
  assign mem_req    = mem_req_r;
  assign mem_addr   = pc_r;
  assign IR         = ir_r;
  assign IR_valid   = ir_valid_r;
  assign fetch_busy = busy_r;
  assign fault      = fault_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit with hand-computed expectations.
module tb_pc_fetch_unit;

  logic        clock;
  logic        reset;
  logic        pc_update;
  logic [1:0]  PC_FS;
  logic [63:0] k;
  logic [63:0] pc_in;
  logic        fetch_start;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [63:0] PC;
  logic [63:0] PC4;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic [31:0] IR;
  logic        IR_valid;
  logic        fetch_busy;
  logic        fault;

  int checks;
  int errors;

  pc_fetch_unit #(
    .WIDTH(64),
    .RESET_PC(64'h0),
    .FETCH_TIMEOUT(15)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pc_update(pc_update),
    .PC_FS(PC_FS),
    .k(k),
    .pc_in(pc_in),
    .fetch_start(fetch_start),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .PC(PC),
    .PC4(PC4),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .IR(IR),
    .IR_valid(IR_valid),
    .fetch_busy(fetch_busy),
    .fault(fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_pc(input logic [63:0] val);
    pc_update = 1'b1;
    PC_FS     = 2'b10;
    pc_in     = val;
    tick();
    pc_update = 1'b0;
    PC_FS     = 2'b00;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    pc_update   = 1'b0;
    PC_FS       = 2'b00;
    k           = 64'h0;
    pc_in       = 64'h0;
    fetch_start = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = 32'h0;
    tick();
    tick();

    // Reset state
    chk("rst_pc", PC, 64'h0);
    chk("rst_pc4", PC4, 64'h4);
    chk("rst_ir", {32'h0, IR}, 64'h0);
    chk("rst_irv", {63'h0, IR_valid}, 64'h0);
    chk("rst_req", {63'h0, mem_req}, 64'h0);
    chk("rst_fault", {63'h0, fault}, 64'h0);
    chk("rst_busy", {63'h0, fetch_busy}, 64'h0);
    reset = 1'b0;
    tick();

    // Sequential increments then hold
    pc_update = 1'b1;
    PC_FS = 2'b01;
    tick(); tick(); tick();
    chk("inc3_pc", PC, 64'd12);
    PC_FS = 2'b00;
    tick();
    chk("hold_pc", PC, 64'd12);
    chk("hold_pc4", PC4, 64'd16);
    pc_update = 1'b0;

    // Backward branch and register target
    load_pc(64'h100);
    chk("ld_pc", PC, 64'h100);
    k = 64'hFFFF_FFFF_FFFF_FFFE;
    pc_update = 1'b1;
    PC_FS = 2'b11;
    tick();
    chk("br_back", PC, 64'hF8);
    k = 64'h3;
    tick();
    chk("br_fwd", PC, 64'h104);
    pc_in = 64'h4000;
    PC_FS = 2'b10;
    tick();
    chk("br_reg", PC, 64'h4000);
    pc_update = 1'b0;

    // Wrap-around
    load_pc(64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_pc4", PC4, 64'h0);
    pc_update = 1'b1;
    PC_FS = 2'b01;
    tick();
    pc_update = 1'b0;
    chk("wrap_pc", PC, 64'h0);
    chk("wrap_fault", {63'h0, fault}, 64'h0);

    // Fetch with ack in the third REQ cycle; pc_update during REQ ignored
    load_pc(64'h40);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    chk("f_req1", {63'h0, mem_req}, 64'h1);
    chk("f_addr", mem_addr, 64'h40);
    chk("f_busy", {63'h0, fetch_busy}, 64'h1);
    pc_update = 1'b1;
    PC_FS = 2'b01;
    tick();
    pc_update = 1'b0;
    chk("f_req2", {63'h0, mem_req}, 64'h1);
    chk("f_pc_frozen", PC, 64'h40);
    chk("f_irv_low", {63'h0, IR_valid}, 64'h0);
    tick();
    chk("f_req3", {63'h0, mem_req}, 64'h1);
    mem_ack = 1'b1;
    mem_rdata = 32'h9100_0421;
    tick();
    mem_ack = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    chk("f_req_drop", {63'h0, mem_req}, 64'h0);
    chk("f_ir", {32'h0, IR}, 64'h9100_0421);
    chk("f_irv", {63'h0, IR_valid}, 64'h1);
    chk("f_pc_after", PC, 64'h40);
    tick();
    chk("f_irv_pulse", {63'h0, IR_valid}, 64'h0);
    chk("f_ir_hold", {32'h0, IR}, 64'h9100_0421);
    chk("f_busy_end", {63'h0, fetch_busy}, 64'h0);

    // Misaligned fetch faults without requesting
    load_pc(64'h102);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    chk("mis_fault", {63'h0, fault}, 64'h1);
    chk("mis_req", {63'h0, mem_req}, 64'h0);
    pc_update = 1'b1;
    PC_FS = 2'b01;
    fetch_start = 1'b1;
    tick();
    tick();
    pc_update = 1'b0;
    fetch_start = 1'b0;
    chk("mis_pc_frozen", PC, 64'h102);
    chk("mis_req_still", {63'h0, mem_req}, 64'h0);
    chk("mis_sticky", {63'h0, fault}, 64'h1);

    // Timeout after 15 unanswered REQ cycles
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("to_rst_fault", {63'h0, fault}, 64'h0);
    load_pc(64'h80);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      chk($sformatf("to_req_c%0d", i), {62'h0, mem_req, fault}, 64'h2);
      tick();
    end
    chk("to_fault", {63'h0, fault}, 64'h1);
    chk("to_req_drop", {63'h0, mem_req}, 64'h0);
    chk("to_busy", {63'h0, fetch_busy}, 64'h0);

    // Reset mid-REQ drops mem_req asynchronously; late ack ignored
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    chk("ar_req_pre", {63'h0, mem_req}, 64'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_req_async", {63'h0, mem_req}, 64'h0);
    tick();
    reset = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    chk("ar_ir", {32'h0, IR}, 64'h0);
    chk("ar_irv", {63'h0, IR_valid}, 64'h0);

    // Update and fetch together; ack on the 15th REQ cycle succeeds
    load_pc(64'h20);
    pc_update = 1'b1;
    PC_FS = 2'b01;
    fetch_start = 1'b1;
    tick();
    pc_update = 1'b0;
    fetch_start = 1'b0;
    chk("sim_addr", mem_addr, 64'h24);
    chk("sim_req", {63'h0, mem_req}, 64'h1);
    for (int i = 2; i <= 15; i++) begin
      tick();
    end
    chk("sim_req15", {62'h0, mem_req, fault}, 64'h2);
    mem_ack = 1'b1;
    mem_rdata = 32'hA5A5_0001;
    tick();
    mem_ack = 1'b0;
    chk("sim_ir", {32'h0, IR}, 64'hA5A5_0001);
    chk("sim_irv", {63'h0, IR_valid}, 64'h1);
    chk("sim_fault", {63'h0, fault}, 64'h0);
    chk("sim_req_drop", {63'h0, mem_req}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
